// File: rtl/xdatabus_arbiter_if.sv
// xdatabus_arbiter_if: requester-side and master-side databus signals of the arbiter.
interface xdatabus_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*ADDR_W-1:0]   req_addr;
  logic [N_REQ*DATA_W-1:0]   req_wdata;
  logic [N_REQ*DATA_W/8-1:0] req_wstrb;
  logic [N_REQ-1:0]          req_ready;
  logic [DATA_W-1:0]         req_rdata;
  logic                      m_valid;
  logic [ADDR_W-1:0]         m_addr;
  logic [DATA_W-1:0]         m_wdata;
  logic [DATA_W/8-1:0]       m_wstrb;
  logic                      m_ready;
  logic [DATA_W-1:0]         m_rdata;
  modport master (
    input  req_valid, req_addr, req_wdata, req_wstrb, m_ready, m_rdata,
    output req_ready, req_rdata, m_valid, m_addr, m_wdata, m_wstrb
  );
  modport slave (
    output req_valid, req_addr, req_wdata, req_wstrb, m_ready, m_rdata,
    input  req_ready, req_rdata, m_valid, m_addr, m_wdata, m_wstrb
  );
endinterface

// File: rtl/xdatabus_arbiter.sv
// xdatabus_arbiter: round-robin burst arbiter sharing one databus master among N_REQ requesters.
// Define XDATABUS_ARB_FIXED_PRIO_EN to hold rr_ptr at 0 (lowest index always wins).
module xdatabus_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int BURST_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  xdatabus_arbiter_if.master bus,
  output logic [N_REQ-1:0] grant_o,
  output logic             busy_o
);
  localparam int PTR_W  = $clog2(N_REQ);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   g_q, g_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [PTR_W-1:0]   win, idx;
  logic               found, beat, last, rel;

  logic [ADDR_W-1:0] addr_a  [N_REQ];
  logic [DATA_W-1:0] wdata_a [N_REQ];
  logic [STRB_W-1:0] wstrb_a [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign addr_a[k]  = bus.req_addr[k*ADDR_W +: ADDR_W];
    assign wdata_a[k] = bus.req_wdata[k*DATA_W +: DATA_W];
    assign wstrb_a[k] = bus.req_wstrb[k*STRB_W +: STRB_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      g_q        <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      g_q        <= g_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // First asserted valid at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    win   = rr_ptr_q;
    idx   = rr_ptr_q;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!found && bus.req_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    beat       = state_q == BUSY && bus.req_valid[g_q] && bus.m_ready;
    last       = MAX_BURST != 0 && beat && int'(beat_cnt_q) + 1 == MAX_BURST;
    rel        = (!bus.req_valid[g_q] && !beat) || last;
    state_d    = state_q;
    grant_d    = grant_q;
    g_d        = g_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = BUSY;
        grant_d = N_REQ'(1) << win;
        g_d     = win;
      end
    end else if (rel) begin
      state_d    = IDLE;
      grant_d    = '0;
      beat_cnt_d = '0;
      rr_ptr_d   = (int'(g_q) == N_REQ - 1) ? '0 : g_q + 1'b1;
    end else if (beat) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
`ifdef XDATABUS_ARB_FIXED_PRIO_EN
    rr_ptr_d = '0;
`endif
  end

  always_comb begin
    busy_o        = state_q == BUSY;
    grant_o       = grant_q;
    bus.m_valid   = busy_o && bus.req_valid[g_q];
    bus.m_addr    = addr_a[g_q];
    bus.m_wdata   = wdata_a[g_q];
    bus.m_wstrb   = busy_o ? wstrb_a[g_q] : '0;
    bus.req_ready = busy_o ? {{(N_REQ-1){1'b0}}, bus.m_ready} << g_q : '0;
    bus.req_rdata = bus.m_rdata;
  end
endmodule

// File: tb/tb_xdatabus_arbiter.sv
// tb_xdatabus_arbiter: directed checks of grant sequencing, bursts, stalls, data muxing and async reset.
module tb_xdatabus_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] grant;
  logic         busy;
  int           total = 0;
  int           bad = 0;

  xdatabus_arbiter_if #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  xdatabus_arbiter #(
    .N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(4), .BURST_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .grant_o(grant),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Five-cycle period per owner: four beats then a one-cycle bubble.
  function automatic logic [N-1:0] s2_exp(input int c);
`ifdef XDATABUS_ARB_FIXED_PRIO_EN
    return (c % 5 == 4) ? 4'b0000 : 4'b0001;
`else
    return (c % 5 == 4) ? 4'b0000 : 4'b0001 << ((c / 5) % 4);
`endif
  endfunction

  initial begin
    bus.req_valid = 4'b1111;
    bus.req_wstrb = '0;
    bus.m_ready   = 1'b1;
    bus.m_rdata   = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]  = 32'h1000_0000 + 32'(i);
      bus.req_wdata[i*DW +: DW] = 32'hC0DE_0000 + 32'(i);
    end
    #12;
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_wstrb", bus.m_wstrb, 4'h0);
    chk("rst_req_ready", bus.req_ready, 4'b0000);
    tick;
    rst = 1'b0;
    tick;
    for (int c = 0; c <= 26; c++) begin
      chk($sformatf("s2_grant_c%0d", c), grant, s2_exp(c));
      if (c == 0) begin
        chk("s1_busy", busy, 1'b1);
        chk("s1_m_valid", bus.m_valid, 1'b1);
        chk("s1_m_addr", bus.m_addr, 32'h1000_0000);
        chk("s1_req_ready", bus.req_ready, 4'b0001);
      end
      if (c < 26) tick;
    end
    #1 rst = 1'b1;
    #1;
    chk("s6_async_grant", grant, 4'b0000);
    chk("s6_async_m_valid", bus.m_valid, 1'b0);
    chk("s6_async_busy", busy, 1'b0);
    chk("s6_async_req_ready", bus.req_ready, 4'b0000);
    bus.m_ready = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    chk("s6_restart_grant", grant, 4'b0001);
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("s4_stall_grant_%0d", s), grant, 4'b0001);
      chk($sformatf("s4_stall_m_valid_%0d", s), bus.m_valid, 1'b1);
      chk($sformatf("s4_stall_req_ready_%0d", s), bus.req_ready, 4'b0000);
      tick;
    end
    bus.m_ready = 1'b1;
    #1;
    chk("s4_ready_req_ready", bus.req_ready, 4'b0001);
    for (int c = 0; c <= 4; c++) begin
      chk($sformatf("s4_burst_grant_c%0d", c), grant, (c < 4) ? 4'b0001 : 4'b0000);
      if (c < 4) tick;
    end
    bus.req_valid           = 4'b0010;
    bus.req_wstrb[4 +: 4]   = 4'hF;
    bus.req_wdata[DW +: DW] = 32'h1234_5678;
    bus.m_rdata             = 32'hDEAD_BEEF;
    #1;
    chk("s5_rdata_idle", bus.req_rdata, 32'hDEAD_BEEF);
    tick;
    chk("s5_wr_grant", grant, 4'b0010);
    chk("s5_wr_m_wdata", bus.m_wdata, 32'h1234_5678);
    chk("s5_wr_m_wstrb", bus.m_wstrb, 4'hF);
    chk("s5_wr_m_addr", bus.m_addr, 32'h1000_0001);
    chk("s5_wr_req_ready", bus.req_ready, 4'b0010);
    tick;
    bus.req_valid = 4'b0100;
    #1;
    chk("s5_drop_m_valid", bus.m_valid, 1'b0);
    tick;
    chk("s5_drop_grant", grant, 4'b0000);
    chk("s5_drop_busy", busy, 1'b0);
    tick;
    chk("s3_grant", grant, 4'b0100);
    chk("s3_m_wstrb", bus.m_wstrb, 4'h0);
    chk("s3_req_rdata", bus.req_rdata, 32'hDEAD_BEEF);
    chk("s3_m_addr", bus.m_addr, 32'h1000_0002);
    tick;
    tick;
    tick;
    chk("s3_after3_grant", grant, 4'b0100);
    bus.req_valid = 4'b0000;
    #1;
    chk("s3_drop_m_valid", bus.m_valid, 1'b0);
    tick;
    chk("s3_idle_grant", grant, 4'b0000);
    chk("s3_idle_busy", busy, 1'b0);
    bus.req_valid = 4'b0110;
    tick;
    chk("s3_rr_grant", grant, 4'b0010);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
